sig_capture_unit: RTL and testbench
===================================

Name: sig_capture_unit

Overview:
- Receive-side counterpart of the playback path.
- Samples a serial bit stream (dIn qualified by dEnable, one bit per bitStrobe pulse) and packs bits MSB-first into 32-bit words.
- Buffers the words in a small FIFO and presents them to the BRAM controller write port with base address and word count, so captured signals land in the same BRAM image the playback unit reads.

Parameters:
- WORD_W, 32, packed word width.
- CNT_W, 16, width of word counters and numWords.
- ADDR_W, 16, BRAM word address width.
- FIFO_DEPTH, 4, word buffer depth (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- enable  in  1  level; arm and hold capture; deassert to abort or to release DONE.
- baseAddr  in  ADDR_W  first BRAM word address, latched on arm.
- numWords  in  CNT_W  words to capture, latched on arm.
- bitStrobe  in  1  one-clk pulse per serial bit period.
- dIn  in  1  serial data, sampled when bitStrobe=1.
- dEnable  in  1  frame valid, sampled when bitStrobe=1.
- writeData  out  WORD_W  FIFO head word.
- writeValid  out  1  FIFO non-empty.
- writeAck  in  1  controller consumed head; pops FIFO; ignored when writeValid=0.
- writeAddr  out  ADDR_W  baseAddr + words popped; address of writeData.
- writeCount  out  CNT_W  words pushed since arm, including a partial word.
- writeReq  out  1  high in CAPTURE/DRAIN while FIFO non-empty or capture not finished.
- complete  out  1  high in DONE.
- partial  out  1  sticky; last word was zero-padded.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset (async): state=IDLE, shift register/bit counter/FIFO cleared, all outputs 0, writeData=0.
- States: IDLE, ARM, CAPTURE, DRAIN, DONE.
- IDLE:
  - enable=1 latches baseAddr/numWords, clears counters, partial, overflow, FIFO.
  - numWords=0 goes to DONE; otherwise goes to ARM.
- ARM: waits for bitStrobe&dEnable. That same strobe shifts in the first bit; next state CAPTURE.
- CAPTURE:
  - Each bitStrobe&dEnable: shift = {shift[30:0], dIn}, bitCnt++.
  - On the 32nd bit the word is pushed at that clk edge. writeValid rises the next cycle if the FIFO was empty. writeCount increments.
  - When pushed words reach numWords, go to DRAIN; further strobes are ignored.
  - bitStrobe with dEnable=0 and bitCnt>0: push shift<<(32-bitCnt) (left-aligned, LSBs zero), set partial, go to DRAIN.
  - bitStrobe with dEnable=0 and bitCnt=0: go to DRAIN.
- FIFO full at push: word dropped, overflow=1, writeCount still increments, state flow unchanged.
- Push and writeAck in the same cycle: both take effect; occupancy unchanged, including when full (then no overflow).
- DRAIN: no capture. When the FIFO is empty, go to DONE.
- DONE: complete=1, writeReq=0. When enable=0, go to IDLE; complete clears.
- enable=0 in ARM/CAPTURE/DRAIN: abort to IDLE next cycle, FIFO flushed, complete never asserted.
- writeAddr: baseAddr + popCount, CNT_W-bit add truncated to ADDR_W, wraps modulo 2^ADDR_W.
- writeAck with writeValid=0: no effect, no counter change.
- bitStrobe asserted on consecutive clocks: must be supported, one bit per clock.

Decomposition:
- capture_pkg: state enum cap_state_t {IDLE, ARM, CAPTURE, DRAIN, DONE}; WORD_W and CNT_W defaults; function left-aligning a partial word.
- Sub-module sync_fifo (WIDTH, DEPTH):
  - Signals: push/pop/full/empty/count, head visible combinationally.
  - Simultaneous push+pop allowed when full.
  - Also usable by the playback side.

Test Plan:
- Basic capture: numWords=2, baseAddr=8; stream 0x6F3B2A1C then 0x12345678 MSB-first, writeAck held 1.
  - Two pops with writeAddr 8 then 9 and matching data.
  - writeCount=2, complete=1, partial=0, overflow=0.
- Partial frame: numWords=4; stream 0xEABC9724, then 12 bits 0x456, then dEnable=0 on the next strobe.
  - Words 0xEABC9724 and 0x45600000.
  - partial=1, writeCount=2, complete=1.
- Backpressure/overflow: FIFO_DEPTH=4, numWords=6, writeAck=0 throughout capture.
  - overflow=1, writeValid=1, exactly 4 words (the first four) retrievable after writeAck is asserted, then DONE.
- Zero and wrap: numWords=0 gives complete=1 one cycle after enable.
  - baseAddr=0xFFFF with numWords=2 gives writeAddr 0xFFFF then 0x0000.
- Abort and reset: drop enable after 40 bits gives IDLE, writeValid=0, no complete.
  - Pulse reset mid-word gives all outputs 0 immediately.
  - Re-arm and capture 0x33333333 correctly.
- Back-to-back strobes: bitStrobe=1 every clk for 64 bits gives 2 correct words with no lost bits; simultaneous push+pop at a full FIFO does not set overflow.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types, default widths and helpers for the signal capture path.
package capture_pkg;

  localparam int unsigned DEF_WORD_W     = 32;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_BITCNT_W   = $clog2(DEF_WORD_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    DRAIN,
    DONE
  } cap_state_t;

  // Move the nbits most recent bits to the top of the word and zero-fill the LSBs.
  function automatic logic [DEF_WORD_W-1:0] left_align(
    input logic [DEF_WORD_W-1:0]   word,
    input logic [DEF_BITCNT_W-1:0] nbits
  );
    return word << (DEF_BITCNT_W'(DEF_WORD_W) - nbits);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head word visible without a pop, push+pop allowed when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [CNT_W-1:0] count_next_c;

  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);
  assign head_c    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_c = count;
    case ({do_push_c, do_pop_c})
      2'b10:   count_next_c = count + CNT_W'(1);
      2'b01:   count_next_c = count - CNT_W'(1);
      default: count_next_c = count;
    endcase
  end

  // Storage, pointers and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next_c;
      full  <= (count_next_c == CNT_W'(DEPTH));
      empty <= (count_next_c == '0);
    end
  end

endmodule

// File: rtl/sig_capture_unit.sv
// Serial capture: packs strobed bits MSB-first into words and queues them for the BRAM write port.
module sig_capture_unit
  import capture_pkg::*;
#(
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [CNT_W-1:0]  numWords,
  input  logic              bitStrobe,
  input  logic              dIn,
  input  logic              dEnable,
  output logic [WORD_W-1:0] writeData,
  output logic              writeValid,
  input  logic              writeAck,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [CNT_W-1:0]  writeCount,
  output logic              writeReq,
  output logic              complete,
  output logic              partial,
  output logic              overflow
);

  localparam int unsigned BITCNT_W = $clog2(WORD_W) + 1;
  localparam int unsigned LAST_BIT = WORD_W - 1;
  localparam int unsigned FCNT_W   = $clog2(FIFO_DEPTH) + 1;

  cap_state_t          state;
  cap_state_t          next_state;
  logic [ADDR_W-1:0]   base_addr;
  logic [CNT_W-1:0]    num_words;
  logic [WORD_W-1:0]   shift_q;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0]    push_cnt;
  logic [CNT_W-1:0]    pop_cnt;
  logic                partial_q;
  logic                overflow_q;

  logic                arm_c;
  logic                flush_c;
  logic                shift_en_c;
  logic                push_c;
  logic                pop_c;
  logic                set_partial_c;
  logic [WORD_W-1:0]   shifted_c;
  logic [WORD_W-1:0]   push_data_c;
  logic                bit_in_c;
  logic                frame_end_c;

  logic                fifo_full;
  logic                fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;
  logic                unused_fifo_count;
  logic [CNT_W-1:0]    addr_sum;

  assign bit_in_c    = bitStrobe & dEnable;
  assign frame_end_c = bitStrobe & ~dEnable;
  assign shifted_c   = {shift_q[WORD_W-2:0], dIn};
  assign pop_c       = writeAck & ~fifo_empty & ~flush_c;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and per-cycle datapath controls.
  always_comb begin
    next_state    = state;
    arm_c         = 1'b0;
    flush_c       = 1'b0;
    shift_en_c    = 1'b0;
    push_c        = 1'b0;
    set_partial_c = 1'b0;
    push_data_c   = shifted_c;
    case (state)
      IDLE: begin
        if (enable) begin
          arm_c      = 1'b1;
          flush_c    = 1'b1;
          next_state = (numWords == '0) ? DONE : ARM;
        end
      end
      ARM: begin
        if (!enable) begin
          flush_c    = 1'b1;
          next_state = IDLE;
        end else if (bit_in_c) begin
          shift_en_c = 1'b1;
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!enable) begin
          flush_c    = 1'b1;
          next_state = IDLE;
        end else if (bit_in_c) begin
          shift_en_c = 1'b1;
          if (bit_cnt == BITCNT_W'(LAST_BIT)) begin
            push_c = 1'b1;
            if ((push_cnt + CNT_W'(1)) == num_words) next_state = DRAIN;
          end
        end else if (frame_end_c) begin
          if (bit_cnt != '0) begin
            push_c        = 1'b1;
            set_partial_c = 1'b1;
            push_data_c   = WORD_W'(left_align(DEF_WORD_W'(shift_q), DEF_BITCNT_W'(bit_cnt)));
          end
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!enable) begin
          flush_c    = 1'b1;
          next_state = IDLE;
        end else if (fifo_empty) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (!enable) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture datapath: latched setup, shift register, counters and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_addr  <= '0;
      num_words  <= '0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      push_cnt   <= '0;
      pop_cnt    <= '0;
      partial_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (arm_c) begin
        base_addr  <= baseAddr;
        num_words  <= numWords;
        shift_q    <= '0;
        bit_cnt    <= '0;
        push_cnt   <= '0;
        pop_cnt    <= '0;
        partial_q  <= 1'b0;
        overflow_q <= 1'b0;
      end
      if (shift_en_c) begin
        shift_q <= shifted_c;
        bit_cnt <= (bit_cnt == BITCNT_W'(LAST_BIT)) ? '0 : bit_cnt + BITCNT_W'(1);
      end
      if (push_c) begin
        push_cnt <= push_cnt + CNT_W'(1);
        if (fifo_full && !pop_c) overflow_q <= 1'b1;
      end
      if (set_partial_c) partial_q <= 1'b1;
      if (pop_c)         pop_cnt   <= pop_cnt + CNT_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush_c),
    .push   (push_c),
    .pop    (pop_c),
    .wdata  (push_data_c),
    .head_c (writeData),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  // Address of the head word wraps within the BRAM address space.
  assign addr_sum   = CNT_W'(base_addr) + pop_cnt;
  assign writeAddr  = ADDR_W'(addr_sum);
  assign writeValid = ~fifo_empty;
  assign writeCount = push_cnt;
  assign writeReq   = (state == CAPTURE) || ((state == DRAIN) && !fifo_empty);
  assign complete   = (state == DONE);
  assign partial    = partial_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sig_capture_unit.sv
// Directed bench for sig_capture_unit: bit streams in, popped words/addresses checked against expectations.
module tb_sig_capture_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] baseAddr;
  logic [15:0] numWords;
  logic        bitStrobe;
  logic        dIn;
  logic        dEnable;
  logic [31:0] writeData;
  logic        writeValid;
  logic        writeAck;
  logic [15:0] writeAddr;
  logic [15:0] writeCount;
  logic        writeReq;
  logic        complete;
  logic        partial;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] pop_data[$];
  logic [15:0] pop_addr[$];
  logic [31:0] exp_words[$];

  always #5 clk = ~clk;

  sig_capture_unit dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .baseAddr   (baseAddr),
    .numWords   (numWords),
    .bitStrobe  (bitStrobe),
    .dIn        (dIn),
    .dEnable    (dEnable),
    .writeData  (writeData),
    .writeValid (writeValid),
    .writeAck   (writeAck),
    .writeAddr  (writeAddr),
    .writeCount (writeCount),
    .writeReq   (writeReq),
    .complete   (complete),
    .partial    (partial),
    .overflow   (overflow)
  );

  // Record every accepted word just after inputs settle for the coming edge.
  always @(negedge clk) begin
    #1;
    if (!reset && writeValid && writeAck) begin
      pop_data.push_back(writeData);
      pop_addr.push_back(writeAddr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input bit gap, input bit ack_last);
    for (int i = n - 1; i >= 0; i--) begin
      bitStrobe = 1'b1;
      dEnable   = 1'b1;
      dIn       = w[i];
      if (ack_last && i == 0) writeAck = 1'b1;
      @(negedge clk);
      if (ack_last && i == 0) writeAck = 1'b0;
      if (gap) begin
        bitStrobe = 1'b0;
        @(negedge clk);
      end
    end
    bitStrobe = 1'b0;
  endtask

  task automatic end_frame();
    bitStrobe = 1'b1;
    dEnable   = 1'b0;
    @(negedge clk);
    bitStrobe = 1'b0;
  endtask

  task automatic arm(input logic [15:0] base, input logic [15:0] n);
    pop_data.delete();
    pop_addr.delete();
    exp_words.delete();
    baseAddr = base;
    numWords = n;
    enable   = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_enable();
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_complete(input string tag);
    int n = 0;
    while (complete !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(complete), 32'd1);
  endtask

  task automatic check_pops(input string tag, input logic [15:0] base);
    check_eq({tag, "_n"}, 32'(pop_data.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < pop_data.size(); i++) begin
      check_eq({tag, "_data"}, pop_data[i], exp_words[i]);
      check_eq({tag, "_addr"}, 32'(pop_addr[i]), 32'(16'(base + 16'(i))));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wdata"}, writeData, 32'd0);
    check_eq({tag, "_wvalid"}, 32'(writeValid), 32'd0);
    check_eq({tag, "_waddr"}, 32'(writeAddr), 32'd0);
    check_eq({tag, "_wcount"}, 32'(writeCount), 32'd0);
    check_eq({tag, "_wreq"}, 32'(writeReq), 32'd0);
    check_eq({tag, "_complete"}, 32'(complete), 32'd0);
    check_eq({tag, "_partial"}, 32'(partial), 32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    reset     = 1'b1;
    enable    = 1'b0;
    baseAddr  = '0;
    numWords  = '0;
    bitStrobe = 1'b0;
    dIn       = 1'b0;
    dEnable   = 1'b0;
    writeAck  = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    step(1);

    // Basic two-word capture with the controller always accepting.
    writeAck = 1'b1;
    arm(16'd8, 16'd2);
    send_bits(32'h6F3B2A1C, 32, 1'b1, 1'b0);
    check_eq("basic_wreq_capture", 32'(writeReq), 32'd1);
    send_bits(32'h12345678, 32, 1'b1, 1'b0);
    wait_complete("basic_done");
    exp_words.push_back(32'h6F3B2A1C);
    exp_words.push_back(32'h12345678);
    check_pops("basic", 16'd8);
    check_eq("basic_count", 32'(writeCount), 32'd2);
    check_eq("basic_partial", 32'(partial), 32'd0);
    check_eq("basic_overflow", 32'(overflow), 32'd0);
    check_eq("basic_wreq_done", 32'(writeReq), 32'd0);
    release_enable();
    check_eq("basic_release", 32'(complete), 32'd0);

    // Frame ends after 12 bits of the second word.
    arm(16'h0020, 16'd4);
    send_bits(32'hEABC9724, 32, 1'b1, 1'b0);
    send_bits(32'h00000456, 12, 1'b1, 1'b0);
    end_frame();
    wait_complete("partial_done");
    exp_words.push_back(32'hEABC9724);
    exp_words.push_back(32'h45600000);
    check_pops("partial", 16'h0020);
    check_eq("partial_flag", 32'(partial), 32'd1);
    check_eq("partial_count", 32'(writeCount), 32'd2);
    release_enable();

    // No acceptance during capture: four words fit, two are dropped.
    writeAck = 1'b0;
    arm(16'd0, 16'd6);
    for (int k = 0; k < 6; k++) begin
      w = 32'(32'h11111111 * (k + 1));
      send_bits(w, 32, 1'b1, 1'b0);
    end
    step(3);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_wvalid", 32'(writeValid), 32'd1);
    check_eq("ovf_count", 32'(writeCount), 32'd6);
    check_eq("ovf_wreq", 32'(writeReq), 32'd1);
    check_eq("ovf_not_done", 32'(complete), 32'd0);
    writeAck = 1'b1;
    wait_complete("ovf_done");
    for (int k = 0; k < 4; k++) exp_words.push_back(32'(32'h11111111 * (k + 1)));
    check_pops("ovf", 16'd0);
    release_enable();

    // Zero-length capture finishes immediately.
    arm(16'h1234, 16'd0);
    check_eq("zero_complete", 32'(complete), 32'd1);
    check_eq("zero_count", 32'(writeCount), 32'd0);
    check_eq("zero_wreq", 32'(writeReq), 32'd0);
    release_enable();

    // Address wraps past the top of the BRAM.
    arm(16'hFFFF, 16'd2);
    send_bits(32'hDEADBEEF, 32, 1'b1, 1'b0);
    send_bits(32'h0BADF00D, 32, 1'b1, 1'b0);
    wait_complete("wrap_done");
    exp_words.push_back(32'hDEADBEEF);
    exp_words.push_back(32'h0BADF00D);
    check_pops("wrap", 16'hFFFF);
    release_enable();

    // Abort after 40 bits.
    writeAck = 1'b0;
    arm(16'h0010, 16'd4);
    send_bits(32'hCAFEF00D, 32, 1'b1, 1'b0);
    send_bits(32'h000000A5, 8, 1'b1, 1'b0);
    check_eq("abort_pre_wvalid", 32'(writeValid), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("abort_wvalid", 32'(writeValid), 32'd0);
    check_eq("abort_wreq", 32'(writeReq), 32'd0);
    check_eq("abort_complete", 32'(complete), 32'd0);
    step(5);
    check_eq("abort_complete_late", 32'(complete), 32'd0);

    // Asynchronous reset in the middle of a word clears every output at once.
    arm(16'h0010, 16'd4);
    send_bits(32'h87654321, 32, 1'b1, 1'b0);
    send_bits(32'h000003FF, 10, 1'b1, 1'b0);
    check_eq("mid_pre_count", 32'(writeCount), 32'd1);
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    step(1);

    // Clean capture after reset.
    writeAck = 1'b1;
    arm(16'd5, 16'd1);
    send_bits(32'h33333333, 32, 1'b1, 1'b0);
    wait_complete("rearm_done");
    exp_words.push_back(32'h33333333);
    check_pops("rearm", 16'd5);
    release_enable();

    // Strobe every clock for 64 bits.
    arm(16'h0040, 16'd2);
    send_bits(32'hA5C30F96, 32, 1'b0, 1'b0);
    send_bits(32'h5A3CF069, 32, 1'b0, 1'b0);
    wait_complete("b2b_done");
    exp_words.push_back(32'hA5C30F96);
    exp_words.push_back(32'h5A3CF069);
    check_pops("b2b", 16'h0040);
    release_enable();

    // Fill the FIFO, then push and pop on the same edge while full.
    writeAck = 1'b0;
    arm(16'h0080, 16'd5);
    for (int k = 0; k < 5; k++) begin
      w = 32'(32'h9E3779B9 * (k + 1));
      send_bits(w, 32, 1'b0, (k == 4));
    end
    step(2);
    check_eq("full_pp_overflow", 32'(overflow), 32'd0);
    check_eq("full_pp_wvalid", 32'(writeValid), 32'd1);
    writeAck = 1'b1;
    wait_complete("full_pp_done");
    for (int k = 0; k < 5; k++) exp_words.push_back(32'(32'h9E3779B9 * (k + 1)));
    check_pops("full_pp", 16'h0080);
    check_eq("full_pp_count", 32'(writeCount), 32'd5);
    check_eq("full_pp_overflow_end", 32'(overflow), 32'd0);
    release_enable();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
